imm_encoder: RTL and testbench

- Inverse of the core's immediate decoder. Takes a 32-bit immediate, an immediate format (I/S/B/U/J) and a base instruction word.
- Scatters the immediate into the correct instruction bit positions and checks that the immediate is encodable in that format.
- Emits the assembled word through a 2-entry output buffer with valid/ready handshakes and keeps saturating statistics counters.
- Sits between the self-test/program generator and the instruction-memory loader.

---
 rtl/imm_encoder_pkg.sv | 31 +++
 rtl/imm_pack.sv | 51 +++++
 rtl/imm_encoder.sv | 87 ++++++++
 tb/tb_imm_encoder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format and error codes for the encoder and the core's immediate decoder.
`default_nettype none

package imm_encoder_pkg;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_SRC   = 2'd3;

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  err;
  } entry_t;

  // True when v[31:lo] are all copies of one bit, i.e. v is a sign extension from bit lo.
  function automatic logic upper_same(input logic [31:0] v, input int unsigned lo);
    logic [31:0] s;
    s = $signed(v) >>> lo;
    return (s == '0) || (s == '1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/imm_pack.sv
// Combinational scatter of an immediate into an instruction word, with encodability check.
`default_nettype none

module imm_pack
  import imm_encoder_pkg::*;
(
  input  logic [31:0] imm,
  input  logic [2:0]  imm_src,
  input  logic [31:0] base,
  output logic [31:0] instr,
  output logic [1:0]  err
);

  logic [31:0] scattered;

  always_comb begin
    scattered = base;
    err       = ERR_OK;
    case (imm_src)
      IMM_I: begin
        scattered = {imm[11:0], base[19:0]};
        if (!upper_same(imm, 11)) err = ERR_RANGE;
      end
      IMM_S: begin
        scattered = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        if (!upper_same(imm, 11)) err = ERR_RANGE;
      end
      IMM_B: begin
        scattered = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        if (imm[0])                  err = ERR_ALIGN;
        else if (!upper_same(imm, 12)) err = ERR_RANGE;
      end
      IMM_U: begin
        scattered = {imm[31:12], base[11:0]};
        if (|imm[11:0]) err = ERR_ALIGN;
      end
      IMM_J: begin
        scattered = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        if (imm[0])                  err = ERR_ALIGN;
        else if (!upper_same(imm, 20)) err = ERR_RANGE;
      end
      default: err = ERR_SRC;
    endcase
  end

  // Unencodable requests pass the base instruction through untouched.
  assign instr = (err == ERR_OK) ? scattered : base;

endmodule

`default_nettype wire

// File: rtl/imm_encoder.sv
// Immediate encoder: packs requests into a 2-entry output FIFO and keeps saturating statistics.
`default_nettype none

module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_imm,
  input  logic [2:0]       in_imm_src,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             cnt_clr
);

  logic [31:0] pk_instr;
  logic [1:0]  pk_err;

  imm_pack u_pack (
    .imm     (in_imm),
    .imm_src (in_imm_src),
    .base    (in_base),
    .instr   (pk_instr),
    .err     (pk_err)
  );

  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  assign in_ready  = (count < 2'd2) && !rst;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = mem[rd_ptr].instr;
  assign out_err   = mem[rd_ptr].err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{instr: pk_instr, err: pk_err};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_cnt <= '0;
      err_cnt <= '0;
    end else if (cnt_clr) begin
      enc_cnt <= '0;
      err_cnt <= '0;
    end else if (push) begin
      if (enc_cnt != '1) enc_cnt <= enc_cnt + 1'b1;
      if ((pk_err != ERR_OK) && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed golden/error/handshake/reset steps plus a randomized round-trip.
`default_nettype none

module tb_imm_encoder;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_imm;
  logic [2:0]    in_imm_src;
  logic [31:0]   in_base;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [1:0]    out_err;
  logic [CW-1:0] enc_cnt;
  logic [CW-1:0] err_cnt;
  logic          cnt_clr;

  imm_encoder #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_imm     (in_imm),
    .in_imm_src (in_imm_src),
    .in_base    (in_base),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_err    (out_err),
    .enc_cnt    (enc_cnt),
    .err_cnt    (err_cnt),
    .cnt_clr    (cnt_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int m_enc  = 0;
  int m_err  = 0;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  src;
    logic [31:0] base;
  } req_t;
  req_t q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Encodability from numeric ranges of the signed immediate.
  function automatic logic [1:0] ref_err(input logic [31:0] imm, input logic [2:0] src);
    int v;
    v = $signed(imm);
    case (src)
      3'd0, 3'd1: return (v < -2048 || v > 2047) ? 2'd1 : 2'd0;
      3'd2: begin
        if (imm[0]) return 2'd2;
        return (v < -4096 || v > 4095) ? 2'd1 : 2'd0;
      end
      3'd3: return (imm[11:0] != 12'd0) ? 2'd2 : 2'd0;
      3'd4: begin
        if (imm[0]) return 2'd2;
        return (v < -1048576 || v > 1048575) ? 2'd1 : 2'd0;
      end
      default: return 2'd3;
    endcase
  endfunction

  // Standard RISC-V immediate decoding.
  function automatic logic [31:0] decode(input logic [31:0] i, input logic [2:0] src);
    case (src)
      3'd0:    return {{20{i[31]}}, i[31:20]};
      3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    return {i[31:12], 12'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] field_mask(input logic [2:0] src);
    case (src)
      3'd0:       return 32'hFFF0_0000;
      3'd1, 3'd2: return 32'hFE00_0F80;
      default:    return 32'hFFFF_F000;
    endcase
  endfunction

  task automatic bump(input logic [1:0] e);
    if (m_enc < CMAX) m_enc++;
    if (e != 2'd0 && m_err < CMAX) m_err++;
  endtask

  // Single request with out_ready high: visible one edge after accept, gone the next.
  task automatic one_shot(input string tag, input logic [31:0] imm, input logic [2:0] src,
                          input logic [31:0] base, input logic [31:0] exp_i, input logic [1:0] exp_e);
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1; in_imm = imm; in_imm_src = src; in_base = base;
    @(posedge clk); #1;
    in_valid = 0;
    bump(exp_e);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_instr"}, out_instr, exp_i);
    check({tag, "_err"}, out_err, exp_e);
    @(posedge clk); #1;
    check({tag, "_drained"}, out_valid, 0);
  endtask

  task automatic clear_counters();
    cnt_clr = 1;
    @(posedge clk); #1;
    cnt_clr = 0;
    m_enc = 0; m_err = 0;
  endtask

  // One random-phase cycle with the currently driven inputs; scoreboard pops then pushes.
  task automatic rnd_cycle();
    req_t   e;
    logic   acc;
    logic   pp;
    logic [1:0] re;
    @(negedge clk);
    acc = in_valid && in_ready;
    pp  = out_valid && out_ready;
    if (pp) begin
      if (q.size() == 0) begin
        check("rnd_unexpected_pop", 1, 0);
      end else begin
        e  = q.pop_front();
        re = ref_err(e.imm, e.src);
        check("rnd_err", out_err, re);
        if (re == 2'd0) begin
          check("rnd_roundtrip", decode(out_instr, e.src), e.imm);
          check("rnd_base_bits", out_instr & ~field_mask(e.src), e.base & ~field_mask(e.src));
        end else begin
          check("rnd_err_passthru", out_instr, e.base);
        end
      end
    end
    if (acc) begin
      q.push_back('{imm: in_imm, src: in_imm_src, base: in_base});
      bump(ref_err(in_imm, in_imm_src));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    rst = 1; in_valid = 0; in_imm = 0; in_imm_src = 0; in_base = 0; out_ready = 1; cnt_clr = 0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_enc_cnt", enc_cnt, 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // Golden encodes
    one_shot("gold_i", 32'hFFFF_FFFF, 3'd0, 32'h0000_0513, 32'hFFF0_0513, 2'd0);
    one_shot("gold_b", 32'd16,        3'd2, 32'h0000_0063, 32'h0000_0863, 2'd0);
    one_shot("gold_j", 32'hFFFF_FFFC, 3'd4, 32'h0000_006F, 32'hFFDF_F06F, 2'd0);
    check("gold_enc_cnt", enc_cnt, 3);
    check("gold_err_cnt", err_cnt, 0);

    // Error cases
    clear_counters();
    one_shot("err_i_range", 32'd2048,       3'd0, 32'h0000_0513, 32'h0000_0513, 2'd1);
    one_shot("err_b_align", 32'd3,          3'd2, 32'h0000_0063, 32'h0000_0063, 2'd2);
    one_shot("err_u_low",   32'h1234_5001,  3'd3, 32'h0000_0537, 32'h0000_0537, 2'd2);
    one_shot("err_src",     32'd4,          3'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'd3);
    check("err_enc_cnt", enc_cnt, 4);
    check("err_err_cnt", err_cnt, 4);

    // Backpressure
    out_ready = 0;
    in_valid = 1; in_imm_src = 3'd0; in_base = 32'h0000_0013; in_imm = 32'd1;
    @(posedge clk); #1;
    check("bp_first_valid", out_valid, 1);
    check("bp_first_instr", out_instr, 32'h0010_0013);
    check("bp_ready_after_1", in_ready, 1);
    in_imm = 32'd2;
    @(posedge clk); #1;
    check("bp_ready_full", in_ready, 0);
    in_imm = 32'd3;
    @(posedge clk); #1;
    check("bp_still_full", in_ready, 0);
    check("bp_head_held", out_instr, 32'h0010_0013);
    out_ready = 1;
    @(posedge clk); #1;
    check("bp_pop1_instr", out_instr, 32'h0020_0013);
    check("bp_pop1_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    check("bp_third_instr", out_instr, 32'h0030_0013);
    check("bp_third_valid", out_valid, 1);
    @(posedge clk); #1;
    check("bp_empty", out_valid, 0);
    bump(0); bump(0); bump(0);
    check("bp_enc_cnt", enc_cnt, m_enc);

    // Counter saturation and clear priority
    clear_counters();
    in_valid = 1; in_imm = 32'd5; in_imm_src = 3'd0; in_base = 32'h13;
    repeat (17) begin
      @(posedge clk); #1;
    end
    check("sat_enc_cnt", enc_cnt, CMAX);
    cnt_clr = 1;
    @(posedge clk); #1;
    cnt_clr = 0; in_valid = 0;
    check("clr_over_inc", enc_cnt, 0);
    check("clr_err_cnt", err_cnt, 0);
    @(posedge clk); #1;
    check("sat_drained", out_valid, 0);
    m_enc = 0; m_err = 0;

    // Asynchronous reset with a full buffer
    out_ready = 0; in_valid = 1; in_imm = 32'd7;
    @(posedge clk); #1;
    in_imm = 32'd8;
    @(posedge clk); #1;
    in_valid = 0;
    check("pre_rst_full", in_ready, 0);
    check("pre_rst_enc", enc_cnt, 2);
    #2 rst = 1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_instr", out_instr, 0);
    check("arst_out_err", out_err, 0);
    check("arst_enc_cnt", enc_cnt, 0);
    check("arst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 0;
    m_enc = 0; m_err = 0;
    @(posedge clk); #1;
    check("arst_release_ready", in_ready, 1);
    check("arst_release_empty", out_valid, 0);
    out_ready = 1;
    one_shot("arst_fresh", 32'h0000_07FF, 3'd0, 32'h0000_0013, 32'h7FF0_0013, 2'd0);
    check("arst_fresh_enc", enc_cnt, 1);

    // Randomized round-trip
    clear_counters();
    for (int n = 0; n < 10000; n++) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0: in_imm = r;
        1: in_imm = {{20{r[11]}}, r[11:0]};
        2: in_imm = {{11{r[20]}}, r[20:0]};
        default: in_imm = {r[31:12], 12'd0};
      endcase
      if ($urandom_range(0, 1) == 1) in_imm[0] = 1'b0;
      in_imm_src = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      in_base    = $urandom;
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      rnd_cycle();
    end
    in_valid = 0; out_ready = 1;
    repeat (3) rnd_cycle();
    check("rnd_sb_empty", q.size(), 0);
    check("rnd_out_idle", out_valid, 0);
    check("rnd_enc_cnt", enc_cnt, m_enc);
    check("rnd_err_cnt", err_cnt, m_err);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
